// File: rtl/epmp_control_unit_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// epmp_control_unit_if
//
// Command and data-memory strobe bundle between the EPMP control unit and
// the ALU / data memory it sequences.
//
// Signals:
//   DM_Addr     8  data-memory address (control unit -> memory)
//   DM_Rd       1  data memory drives the shared data bus while high
//   DM_Wr       1  data memory captures the shared data bus on this edge
//   ALU_En      1  ALU executes ALU_Cmd on this edge
//   ALU_Cmd     4  ALU command code (0xE means hold)
//   ACC_Out_En  1  ALU drives its accumulator onto the shared data bus
//   C           1  registered ALU carry flag (ALU -> control unit)
//
// Modports:
//   master  the control unit (drives strobes, reads carry)
//   slave   the ALU / data-memory side (reads strobes, drives carry)
// ---------------------------------------------------------------------------
interface epmp_control_unit_if;
    logic [7:0] DM_Addr;
    logic       DM_Rd;
    logic       DM_Wr;
    logic       ALU_En;
    logic [3:0] ALU_Cmd;
    logic       ACC_Out_En;
    logic       C;

    modport master (
        output DM_Addr,
        output DM_Rd,
        output DM_Wr,
        output ALU_En,
        output ALU_Cmd,
        output ACC_Out_En,
        input  C
    );

    modport slave (
        input  DM_Addr,
        input  DM_Rd,
        input  DM_Wr,
        input  ALU_En,
        input  ALU_Cmd,
        input  ACC_Out_En,
        output C
    );
endinterface

// File: rtl/epmp_control_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// epmp_control_unit
//
// Instruction sequencer for the EPMP 8-bit accumulator processor. Every
// instruction runs FETCH -> DECODE -> EXEC; HLT parks the machine in HALT
// until Reset_n is asserted. The unit owns PC, IR, branching and halt, and
// issues commands to the ALU and strobes to data memory.
//
// Parameters:
//   PC_W    program counter / program-memory address width
//   NOP_IR  instruction register value while in reset
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   Reset_n   asynchronous active-low reset
//   PM_Addr   program-memory address (always equals PC)
//   PM_Data   instruction from the asynchronous-read program ROM
//   Data_bus  shared 8-bit bus; driven here only for LDI, Z otherwise
//   Halted    high while in HALT
//   Debug_PC  copy of PC
//   alu_bus   ALU command / data-memory strobe bundle (master side)
// ---------------------------------------------------------------------------
module epmp_control_unit #(
    parameter int          PC_W   = 8,
    parameter logic [11:0] NOP_IR = 12'hE00
) (
    input  logic                clk,
    input  logic                Reset_n,
    output logic [PC_W-1:0]     PM_Addr,
    input  logic [11:0]         PM_Data,
    inout  wire  [7:0]          Data_bus,
    output logic                Halted,
    output logic [PC_W-1:0]     Debug_PC,
    epmp_control_unit_if.master alu_bus
);

    // Opcodes held in IR[11:8]
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_LDA = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_STA = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JC  = 4'hC;
    localparam logic [3:0] OP_JNC = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU command codes that do not follow directly from an opcode
    localparam logic [3:0] CMD_LOAD = 4'h8;
    localparam logic [3:0] CMD_HOLD = 4'hE;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [11:0]     ir;
    logic [3:0]      opcode;
    logic            dm_rd;
    logic            dm_wr;
    logic            alu_en;
    logic [3:0]      alu_cmd;
    logic            acc_out_en;
    logic            ldi_drive;
    logic            halted;
    logic            jump_taken;

    assign opcode = ir[11:8];

    // Instructions whose operand is a data-memory address that must be read
    // onto the bus before the ALU consumes it.
    function automatic logic reads_memory(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_LDA);
    endfunction

    // Opcodes 0..9 all end in an ALU operation (LDI loads the immediate).
    function automatic logic uses_alu(input logic [3:0] op);
        return op <= OP_LDI;
    endfunction

    // ALU_Cmd mirrors the opcode during EXEC. The ALU has no command 9, so
    // LDI is presented as LOAD; the immediate reaches the ALU over the bus.
    function automatic logic [3:0] alu_cmd_for(input logic [3:0] op);
        return (op == OP_LDI) ? CMD_LOAD : op;
    endfunction

    // Branch resolution. The carry arrives registered from the ALU, so
    // during EXEC it already reflects the previous instruction's result.
    // It only steers the PC update and never reaches an output directly.
    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            OP_JMP:  jump_taken = 1'b1;
            OP_JC:   jump_taken = alu_bus.C;
            OP_JNC:  jump_taken = ~alu_bus.C;
            default: jump_taken = 1'b0;
        endcase
    end

    // Sequencer. All strobes are registered: each state computes the
    // outputs for the state it is entering, so the output flops hold what
    // the current state and IR call for. The one-cycle strobes (ALU_En,
    // DM_Wr, ACC_Out_En) default low every cycle and are only raised on the
    // DECODE->EXEC edge. DM_Rd and the LDI bus drive are raised on the
    // FETCH->DECODE edge from the incoming instruction and kept through
    // EXEC. STA never reads, so the three bus drivers stay mutually
    // exclusive. The asynchronous reset also pulls every strobe low at
    // once, which cancels a pending STA write.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= FETCH;
            pc         <= '0;
            ir         <= NOP_IR;
            dm_rd      <= 1'b0;
            dm_wr      <= 1'b0;
            alu_en     <= 1'b0;
            alu_cmd    <= CMD_HOLD;
            acc_out_en <= 1'b0;
            ldi_drive  <= 1'b0;
            halted     <= 1'b0;
        end else begin
            dm_wr      <= 1'b0;
            alu_en     <= 1'b0;
            acc_out_en <= 1'b0;
            alu_cmd    <= CMD_HOLD;
            case (state)
                FETCH: begin
                    ir        <= PM_Data;
                    pc        <= pc + PC_W'(1);
                    dm_rd     <= reads_memory(PM_Data[11:8]);
                    ldi_drive <= (PM_Data[11:8] == OP_LDI);
                    state     <= DECODE;
                end
                DECODE: begin
                    alu_en     <= uses_alu(opcode);
                    alu_cmd    <= alu_cmd_for(opcode);
                    acc_out_en <= (opcode == OP_STA);
                    dm_wr      <= (opcode == OP_STA);
                    state      <= EXEC;
                end
                EXEC: begin
                    dm_rd     <= 1'b0;
                    ldi_drive <= 1'b0;
                    if (jump_taken) begin
                        pc <= PC_W'(ir[7:0]);
                    end
                    if (opcode == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALT: begin
                    dm_rd     <= 1'b0;
                    ldi_drive <= 1'b0;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign PM_Addr            = pc;
    assign Debug_PC           = pc;
    assign Halted             = halted;
    assign alu_bus.DM_Addr    = ir[7:0];
    assign alu_bus.DM_Rd      = dm_rd;
    assign alu_bus.DM_Wr      = dm_wr;
    assign alu_bus.ALU_En     = alu_en;
    assign alu_bus.ALU_Cmd    = alu_cmd;
    assign alu_bus.ACC_Out_En = acc_out_en;

    // The immediate of LDI is the operand field of IR.
    assign Data_bus = ldi_drive ? ir[7:0] : 8'bz;

endmodule
